// File: rtl/goa_loader_pkg.sv
// Shared types and frame geometry for the GOA SPI configuration loader.
// GOA_LOADER_PARITY_EN appends an odd-parity bit to every frame.
package goa_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_COMMIT
    } state_t;

    localparam logic RW_WRITE = 1'b1;

`ifdef GOA_LOADER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int frame_bits(input int aw, input int dw);
        return 1 + aw + dw + PARITY_BITS;
    endfunction

    localparam int DEF_FRAME_LEN = frame_bits(7, 8);

endpackage

// File: rtl/goa_sync_edge.sv
// Multi-stage synchroniser for one asynchronous pin, with rise/fall pulses
// derived from the synchronised level.
module goa_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;

    // Chain resets low so a pin already low at reset release produces no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], din};
            prev_reg <= sync_reg[STAGES-1];
        end
    end

    assign level = sync_reg[STAGES-1];
    assign rise  = sync_reg[STAGES-1] & ~prev_reg;
    assign fall  = ~sync_reg[STAGES-1] & prev_reg;

endmodule

// File: rtl/goa_spi_loader.sv
// SPI mode-0 frame deserialiser issuing register writes/reads to the GOA core.
// Define GOA_LOADER_PARITY_EN for a trailing odd-parity bit on each frame.
module goa_spi_loader
    import goa_loader_pkg::*;
#(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_sclk_in,
    input  logic                  spi_cs_n_in,
    input  logic                  spi_mosi_in,
    output logic                  spi_miso_out,
    output logic                  spi_miso_oe,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_wr_valid,
    input  logic                  reg_wr_ready,
    output logic                  reg_rd_req,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  overrun,
    output logic                  parity_err
);

    localparam int CMD_BITS  = 1 + ADDR_WIDTH;
    localparam int FRAME_LEN = frame_bits(ADDR_WIDTH, DATA_WIDTH);
    localparam int DATA_SH   = DATA_WIDTH + PARITY_BITS;
    localparam int SH_W      = (CMD_BITS > DATA_SH) ? CMD_BITS : DATA_SH;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    // Pin index: 0 = SCLK, 1 = CS_n, 2 = MOSI.
    logic [2:0] pin_in, pin_lvl, pin_rise, pin_fall;
    assign pin_in = {spi_mosi_in, spi_cs_n_in, spi_sclk_in};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_pin
            goa_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
                .clk   (clk),
                .rst   (rst),
                .din   (pin_in[gi]),
                .level (pin_lvl[gi]),
                .rise  (pin_rise[gi]),
                .fall  (pin_fall[gi])
            );
        end
    endgenerate

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi;
    assign sclk_rise = pin_rise[0];
    assign sclk_fall = pin_fall[0];
    assign cs_rise   = pin_rise[1];
    assign cs_fall   = pin_fall[1];
    assign mosi      = pin_lvl[2];

    logic unused_pins;
    assign unused_pins = ^{pin_lvl[1:0], pin_rise[2], pin_fall[2]};

    state_t                state_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [SH_W-2:0]       sh_reg;
    logic                  rw_reg;
    logic                  rd_wait_reg;
    logic [ADDR_WIDTH-1:0] addr_hold_reg;
    logic [DATA_WIDTH-1:0] wdata_hold_reg;
    logic [DATA_WIDTH-2:0] miso_sh_reg;
    logic                  parity_err_reg;
    logic                  commit_ok;

    logic [SH_W-1:0]       sh_next;
    logic                  wr_held;
    assign sh_next = {sh_reg, mosi};
    assign wr_held = reg_wr_valid & ~reg_wr_ready;

`ifdef GOA_LOADER_PARITY_EN
    logic par_reg, frame_ok_reg;

    // Running XOR of every received bit; odd parity means the total is 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_reg      <= 1'b0;
            frame_ok_reg <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE)
                par_reg <= 1'b0;
            else if (sclk_rise && (state_reg == ST_CMD || state_reg == ST_DATA))
                par_reg <= par_reg ^ mosi;
            if (sclk_rise && state_reg == ST_DATA && cnt_reg == CNT_W'(FRAME_LEN - 1))
                frame_ok_reg <= par_reg ^ mosi;
        end
    end
    assign commit_ok = frame_ok_reg;
`else
    assign commit_ok = 1'b1;
`endif

    assign parity_err = parity_err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            sh_reg         <= '0;
            rw_reg         <= 1'b0;
            rd_wait_reg    <= 1'b0;
            addr_hold_reg  <= '0;
            wdata_hold_reg <= '0;
            miso_sh_reg    <= '0;
            spi_miso_out   <= 1'b0;
            spi_miso_oe    <= 1'b0;
            reg_addr       <= '0;
            reg_wdata      <= '0;
            reg_wr_valid   <= 1'b0;
            reg_rd_req     <= 1'b0;
            overrun        <= 1'b0;
            parity_err_reg <= 1'b0;
        end else begin
            reg_rd_req  <= 1'b0;
            rd_wait_reg <= reg_rd_req;
            if (reg_wr_valid && reg_wr_ready)
                reg_wr_valid <= 1'b0;

            // Read data arrives the cycle after the strobe; present its MSB at once.
            if (rd_wait_reg && state_reg == ST_DATA) begin
                miso_sh_reg  <= reg_rdata[DATA_WIDTH-2:0];
                spi_miso_out <= reg_rdata[DATA_WIDTH-1];
                spi_miso_oe  <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_reg <= ST_CMD;
                        cnt_reg   <= '0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        sh_reg  <= sh_next[SH_W-2:0];
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == CNT_W'(CMD_BITS - 1)) begin
                            state_reg     <= ST_DATA;
                            rw_reg        <= sh_next[CMD_BITS-1];
                            addr_hold_reg <= sh_next[ADDR_WIDTH-1:0];
                            // Keep the presented address stable under a held write.
                            if (!wr_held)
                                reg_addr <= sh_next[ADDR_WIDTH-1:0];
                            if (sh_next[CMD_BITS-1] != RW_WRITE)
                                reg_rd_req <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (sclk_rise) begin
                        sh_reg  <= sh_next[SH_W-2:0];
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == CNT_W'(FRAME_LEN - 1)) begin
                            if (rw_reg == RW_WRITE) begin
                                state_reg      <= ST_COMMIT;
                                wdata_hold_reg <= sh_next[PARITY_BITS +: DATA_WIDTH];
                            end else begin
                                state_reg    <= ST_IDLE;
                                spi_miso_oe  <= 1'b0;
                                spi_miso_out <= 1'b0;
                            end
                        end
                    end else if (sclk_fall && rw_reg != RW_WRITE && cnt_reg > CNT_W'(CMD_BITS)) begin
                        // The falling edge before the first data rise keeps the MSB on the pin.
                        spi_miso_out <= miso_sh_reg[DATA_WIDTH-2];
                        miso_sh_reg  <= miso_sh_reg << 1;
                    end
                end
                ST_COMMIT: begin
                    state_reg <= ST_IDLE;
                    if (!commit_ok) begin
                        parity_err_reg <= 1'b1;
                    end else if (reg_wr_valid) begin
                        overrun <= 1'b1;
                    end else begin
                        reg_wr_valid <= 1'b1;
                        reg_addr     <= addr_hold_reg;
                        reg_wdata    <= wdata_hold_reg;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            if (cs_rise && state_reg != ST_IDLE) begin
                state_reg    <= ST_IDLE;
                spi_miso_oe  <= 1'b0;
                spi_miso_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_goa_spi_loader.sv
// Directed self-checking bench for goa_spi_loader (default or GOA_LOADER_PARITY_EN build).
module tb_goa_spi_loader;

    localparam int HALF = 6;
`ifdef GOA_LOADER_PARITY_EN
    localparam int FT = 17;
`else
    localparam int FT = 16;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b0;
    logic       mosi = 1'b0;
    logic       wr_ready = 1'b0;
    logic [7:0] rdata_q = 8'h00;

    logic       spi_miso_out, spi_miso_oe;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr_valid, reg_rd_req, overrun, parity_err;

    int tests_run = 0;
    int tests_failed = 0;

    int         wr_cnt = 0;
    int         rd_cnt = 0;
    logic [6:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [6:0] rd_addr = '0;

    always #5 clk = ~clk;

    goa_spi_loader dut (
        .clk          (clk),
        .rst          (rst),
        .spi_sclk_in  (sclk),
        .spi_cs_n_in  (cs_n),
        .spi_mosi_in  (mosi),
        .spi_miso_out (spi_miso_out),
        .spi_miso_oe  (spi_miso_oe),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_wr_valid (reg_wr_valid),
        .reg_wr_ready (wr_ready),
        .reg_rd_req   (reg_rd_req),
        .reg_rdata    (rdata_q),
        .overrun      (overrun),
        .parity_err   (parity_err)
    );

    // Core model: read data valid the cycle after the strobe, garbage otherwise.
    always @(posedge clk) rdata_q <= reg_rd_req ? 8'hA7 : 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            if (reg_wr_valid && wr_ready) begin
                wr_cnt++;
                wr_addr = reg_addr;
                wr_data = reg_wdata;
            end
            if (reg_rd_req) begin
                rd_cnt++;
                rd_addr = reg_addr;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [16:0] mk(input logic rw, input logic [6:0] a,
                                       input logic [7:0] d, input logic flip);
        logic [15:0] f;
        f = {rw, a, d};
`ifdef GOA_LOADER_PARITY_EN
        return {f, (~^f) ^ flip};
`else
        return {flip, f};
`endif
    endfunction

    task automatic cs_low();
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, output logic miso_s, output logic oe_s);
        mosi = b;
        repeat (HALF) @(negedge clk);
        sclk   = 1'b1;
        miso_s = spi_miso_out;
        oe_s   = spi_miso_oe;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [16:0] fr, input int first, input int nbits,
                             output logic [15:0] miso_v, output logic [15:0] oe_v);
        logic m, o;
        miso_v = '0;
        oe_v   = '0;
        for (int i = first; i < first + nbits; i++) begin
            send_bit(fr[FT-1-i], m, o);
            if (i < 16) begin
                miso_v[15-i] = m;
                oe_v[15-i]   = o;
            end
        end
    endtask

    task automatic test_reset();
        logic [15:0] mv, ov;
        rst = 1'b1;
        cs_n = 1'b0;
        repeat (3) @(negedge clk);
        if ({spi_miso_out, spi_miso_oe, reg_addr, reg_wdata, reg_wr_valid, reg_rd_req, overrun, parity_err} !== 21'h0) begin
            tests_failed++;
            $display("FAIL reset_values: got %0h expected 0", {spi_miso_out, spi_miso_oe, reg_addr, reg_wdata, reg_wr_valid, reg_rd_req, overrun, parity_err});
        end
        tests_run++;
        rst = 1'b0;
        wr_ready = 1'b1;
        // CS_n already low at release: clocking a frame must not start anything.
        send_bits(mk(1'b1, 7'h05, 8'h3C, 1'b0), 0, FT, mv, ov);
        cs_high();
        tests_run++;
        if (wr_cnt !== 0 || rd_cnt !== 0) begin
            tests_failed++;
            $display("FAIL cs_low_at_release: got wr=%0d rd=%0d expected 0/0", wr_cnt, rd_cnt);
        end
        tests_run++;
        if (reg_wr_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL cs_low_valid: got %b expected 0", reg_wr_valid);
        end
        $display("[TB] reset: frame without CS_n edge ignored");
    endtask

    task automatic test_write();
        logic [15:0] mv, ov;
        int w0;
        w0 = wr_cnt;
        wr_ready = 1'b1;
        cs_low();
        send_bits(mk(1'b1, 7'h05, 8'h3C, 1'b0), 0, FT, mv, ov);
        cs_high();
        $display("[TB] write addr=%02h data=%02h handshakes=%0d", wr_addr, wr_data, wr_cnt - w0);
        tests_run++;
        if (wr_cnt - w0 !== 1) begin
            tests_failed++;
            $display("FAIL write_count: got %0d expected 1", wr_cnt - w0);
        end
        tests_run++;
        if (wr_addr !== 7'h05) begin
            tests_failed++;
            $display("FAIL write_addr: got %02h expected 05", wr_addr);
        end
        tests_run++;
        if (wr_data !== 8'h3C) begin
            tests_failed++;
            $display("FAIL write_data: got %02h expected 3c", wr_data);
        end
        tests_run++;
        if (reg_wr_valid !== 1'b0 || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_after: got valid=%b overrun=%b expected 0/0", reg_wr_valid, overrun);
        end
    endtask

    task automatic test_read();
        logic [15:0] mv, ov;
        int r0, w0;
        r0 = rd_cnt;
        w0 = wr_cnt;
        cs_low();
        send_bits(mk(1'b0, 7'h12, 8'h00, 1'b0), 0, FT, mv, ov);
        cs_high();
        $display("[TB] read addr=%02h miso=%02h strobes=%0d", rd_addr, mv[7:0], rd_cnt - r0);
        tests_run++;
        if (rd_cnt - r0 !== 1) begin
            tests_failed++;
            $display("FAIL read_strobes: got %0d expected 1", rd_cnt - r0);
        end
        tests_run++;
        if (rd_addr !== 7'h12) begin
            tests_failed++;
            $display("FAIL read_addr: got %02h expected 12", rd_addr);
        end
        tests_run++;
        if (mv[7:0] !== 8'hA7) begin
            tests_failed++;
            $display("FAIL read_miso: got %02h expected a7", mv[7:0]);
        end
        tests_run++;
        if (ov !== 16'h00FF) begin
            tests_failed++;
            $display("FAIL read_oe: got %04h expected 00ff", ov);
        end
        tests_run++;
        if (spi_miso_oe !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_oe_idle: got %b expected 0", spi_miso_oe);
        end
        tests_run++;
        if (wr_cnt !== w0 || reg_wr_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_no_write: got wr=%0d valid=%b expected %0d/0", wr_cnt, reg_wr_valid, w0);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] mv, ov;
        int w0;
        w0 = wr_cnt;
        wr_ready = 1'b0;
        cs_low();
        send_bits(mk(1'b1, 7'h01, 8'h11, 1'b0), 0, FT, mv, ov);
        cs_high();
        $display("[TB] write addr=01 data=11 held valid=%b", reg_wr_valid);
        tests_run++;
        if ({reg_wr_valid, reg_addr, reg_wdata, overrun} !== {1'b1, 7'h01, 8'h11, 1'b0}) begin
            tests_failed++;
            $display("FAIL b2b_first: got v=%b a=%02h d=%02h ovr=%b expected 1/01/11/0", reg_wr_valid, reg_addr, reg_wdata, overrun);
        end
        cs_low();
        send_bits(mk(1'b1, 7'h02, 8'h22, 1'b0), 0, FT, mv, ov);
        cs_high();
        $display("[TB] write addr=02 data=22 overrun=%b", overrun);
        tests_run++;
        if (overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_overrun: got %b expected 1", overrun);
        end
        tests_run++;
        if ({reg_wr_valid, reg_addr, reg_wdata} !== {1'b1, 7'h01, 8'h11}) begin
            tests_failed++;
            $display("FAIL b2b_stable: got v=%b a=%02h d=%02h expected 1/01/11", reg_wr_valid, reg_addr, reg_wdata);
        end
        wr_ready = 1'b1;
        repeat (4) @(negedge clk);
        tests_run++;
        if (wr_cnt - w0 !== 1) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d expected 1", wr_cnt - w0);
        end
        tests_run++;
        if (wr_addr !== 7'h01 || wr_data !== 8'h11) begin
            tests_failed++;
            $display("FAIL b2b_accepted: got a=%02h d=%02h expected 01/11", wr_addr, wr_data);
        end
        tests_run++;
        if (reg_wr_valid !== 1'b0 || overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_after: got valid=%b overrun=%b expected 0/1", reg_wr_valid, overrun);
        end
    endtask

    task automatic test_abort();
        logic [15:0] mv, ov;
        int w0;
        w0 = wr_cnt;
        wr_ready = 1'b1;
        cs_low();
        send_bits(mk(1'b1, 7'h05, 8'h3C, 1'b0), 0, 10, mv, ov);
        cs_high();
        $display("[TB] aborted write after 10 bits handshakes=%0d", wr_cnt - w0);
        tests_run++;
        if (wr_cnt !== w0 || reg_wr_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_no_write: got wr=%0d valid=%b expected %0d/0", wr_cnt, reg_wr_valid, w0);
        end
        cs_low();
        send_bits(mk(1'b1, 7'h03, 8'h55, 1'b0), 0, FT, mv, ov);
        cs_high();
        $display("[TB] write addr=%02h data=%02h after abort", wr_addr, wr_data);
        tests_run++;
        if (wr_cnt - w0 !== 1) begin
            tests_failed++;
            $display("FAIL abort_recover_count: got %0d expected 1", wr_cnt - w0);
        end
        tests_run++;
        if (wr_addr !== 7'h03 || wr_data !== 8'h55) begin
            tests_failed++;
            $display("FAIL abort_recover_data: got a=%02h d=%02h expected 03/55", wr_addr, wr_data);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] mv, ov;
        int w0, r0;
        w0 = wr_cnt;
        r0 = rd_cnt;
        wr_ready = 1'b1;
        cs_low();
        send_bits(mk(1'b1, 7'h05, 8'h3C, 1'b0), 0, 12, mv, ov);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({spi_miso_out, spi_miso_oe, reg_addr, reg_wdata, reg_wr_valid, reg_rd_req, overrun, parity_err} !== 21'h0) begin
            tests_failed++;
            $display("FAIL midreset_values: got %0h expected 0", {spi_miso_out, spi_miso_oe, reg_addr, reg_wdata, reg_wr_valid, reg_rd_req, overrun, parity_err});
        end
        rst = 1'b0;
        send_bits(mk(1'b1, 7'h05, 8'h3C, 1'b0), 12, FT - 12, mv, ov);
        cs_high();
        $display("[TB] reset after 12 bits handshakes=%0d strobes=%0d", wr_cnt - w0, rd_cnt - r0);
        tests_run++;
        if (wr_cnt !== w0 || rd_cnt !== r0) begin
            tests_failed++;
            $display("FAIL midreset_no_txn: got wr=%0d rd=%0d expected %0d/%0d", wr_cnt, rd_cnt, w0, r0);
        end
        tests_run++;
        if (reg_wr_valid !== 1'b0 || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_after: got valid=%b overrun=%b expected 0/0", reg_wr_valid, overrun);
        end
    endtask

`ifdef GOA_LOADER_PARITY_EN
    task automatic test_parity();
        logic [15:0] mv, ov;
        int w0;
        w0 = wr_cnt;
        wr_ready = 1'b1;
        cs_low();
        send_bits(mk(1'b1, 7'h05, 8'h3C, 1'b0), 0, FT, mv, ov);
        cs_high();
        $display("[TB] parity-good write addr=%02h data=%02h", wr_addr, wr_data);
        tests_run++;
        if (wr_cnt - w0 !== 1 || wr_addr !== 7'h05 || wr_data !== 8'h3C || parity_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL parity_good: got n=%0d a=%02h d=%02h perr=%b expected 1/05/3c/0", wr_cnt - w0, wr_addr, wr_data, parity_err);
        end
        cs_low();
        send_bits(mk(1'b1, 7'h05, 8'h3C, 1'b1), 0, FT, mv, ov);
        cs_high();
        $display("[TB] parity-bad write parity_err=%b", parity_err);
        tests_run++;
        if (wr_cnt - w0 !== 1 || reg_wr_valid !== 1'b0 || parity_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL parity_bad: got n=%0d valid=%b perr=%b expected 1/0/1", wr_cnt - w0, reg_wr_valid, parity_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_abort();
        test_reset_mid_frame();
`ifdef GOA_LOADER_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
